// File: rtl/axis_string_to_axis_data.sv
// Parses ASCII records "#<hex>;&<hex>;*<hex>\n" into one binary AXIS beat (tdata/tdest/tuser).
// Define AXIS_STRING_TO_DATA_ERR_EN to add the s_err dropped-record pulse output.
module axis_string_to_axis_data #(
    parameter logic [7:0] DELIMITER   = 8'h3B,
    parameter logic [7:0] TERMINATION = 8'h0A,
    parameter int         MBUS_WIDTH  = 1,
    parameter int         USER_WIDTH  = 1,
    parameter int         DEST_WIDTH  = 1,
    parameter logic [7:0] DATA_PREFIX = 8'h23,
    parameter logic [7:0] DEST_PREFIX = 8'h26,
    parameter logic [7:0] USER_PREFIX = 8'h2A
) (
    input  logic                    aclk,
    input  logic                    arstn,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [MBUS_WIDTH*8-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest
`ifdef AXIS_STRING_TO_DATA_ERR_EN
    ,
    output logic                    s_err
`endif
);

    localparam int DATA_W = MBUS_WIDTH * 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIELD,
        ST_DISCARD,
        ST_OUTPUT
    } state_t;

    typedef enum logic [1:0] {
        SEL_DATA,
        SEL_DEST,
        SEL_USER
    } sel_t;

    state_t                  state, state_next;
    sel_t                    sel, sel_next;
    logic [DATA_W-1:0]       data_acc, data_acc_next;
    logic [DEST_WIDTH-1:0]   dest_acc, dest_acc_next;
    logic [USER_WIDTH-1:0]   user_acc, user_acc_next;
    logic                    seen, seen_next;
    logic                    accept;
    logic [4:0]              hex;
    logic                    is_prefix;

    // Returns {valid, nibble} for an ASCII hex digit of either case.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = {1'b1, 4'(c[3:0] + 4'd9)};
        return r;
    endfunction

    assign accept        = s_axis_tvalid && s_axis_tready;
    assign s_axis_tready = (state != ST_OUTPUT);
    assign hex           = hex_decode(s_axis_tdata);
    assign is_prefix     = (s_axis_tdata == DATA_PREFIX) || (s_axis_tdata == DEST_PREFIX)
                        || (s_axis_tdata == USER_PREFIX);

    // The accumulators double as the output registers; they only move outside OUTPUT.
    assign m_axis_tdata = data_acc;
    assign m_axis_tdest = dest_acc;
    assign m_axis_tuser = user_acc;

    always_comb begin
        state_next    = state;
        sel_next      = sel;
        data_acc_next = data_acc;
        dest_acc_next = dest_acc;
        user_acc_next = user_acc;
        seen_next     = seen;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_prefix) begin
                        state_next = ST_FIELD;
                        seen_next  = 1'b1;
                        if (s_axis_tdata == DATA_PREFIX) begin
                            sel_next      = SEL_DATA;
                            data_acc_next = '0;
                        end else if (s_axis_tdata == DEST_PREFIX) begin
                            sel_next      = SEL_DEST;
                            dest_acc_next = '0;
                        end else begin
                            sel_next      = SEL_USER;
                            user_acc_next = '0;
                        end
                    end else if (s_axis_tdata == TERMINATION) begin
                        if (seen)
                            state_next = ST_OUTPUT;
                    end else begin
                        state_next = ST_DISCARD;
                    end
                end
            end

            ST_FIELD: begin
                if (accept) begin
                    if (hex[4]) begin
                        // Shifting left keeps only the most recent digits that fit the field.
                        case (sel)
                            SEL_DATA: data_acc_next = (data_acc << 4) | DATA_W'(hex[3:0]);
                            SEL_DEST: dest_acc_next = (dest_acc << 4) | DEST_WIDTH'(hex[3:0]);
                            default:  user_acc_next = (user_acc << 4) | USER_WIDTH'(hex[3:0]);
                        endcase
                    end else if (s_axis_tdata == DELIMITER) begin
                        state_next = ST_IDLE;
                    end else if (s_axis_tdata == TERMINATION) begin
                        state_next = ST_OUTPUT;
                    end else begin
                        state_next = ST_DISCARD;
                    end
                end
            end

            ST_DISCARD: begin
                if (accept && s_axis_tdata == TERMINATION) begin
                    state_next    = ST_IDLE;
                    data_acc_next = '0;
                    dest_acc_next = '0;
                    user_acc_next = '0;
                    seen_next     = 1'b0;
                end
            end

            default: begin
                if (m_axis_tready) begin
                    state_next    = ST_IDLE;
                    data_acc_next = '0;
                    dest_acc_next = '0;
                    user_acc_next = '0;
                    seen_next     = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state         <= ST_IDLE;
            sel           <= SEL_DATA;
            data_acc      <= '0;
            dest_acc      <= '0;
            user_acc      <= '0;
            seen          <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            state         <= state_next;
            sel           <= sel_next;
            data_acc      <= data_acc_next;
            dest_acc      <= dest_acc_next;
            user_acc      <= user_acc_next;
            seen          <= seen_next;
            m_axis_tvalid <= (state_next == ST_OUTPUT);
        end
    end

`ifdef AXIS_STRING_TO_DATA_ERR_EN
    // One pulse per dropped record: only the entry into DISCARD is flagged.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn)
            s_err <= 1'b0;
        else
            s_err <= (state_next == ST_DISCARD) && (state != ST_DISCARD);
    end
`endif

endmodule
